// File: rtl/store_unit.sv
// store_unit: store buffer with byte-enable formation, LR/SC check, req/gnt drain.
// Define STORE_MISALIGNED_SPLIT_EN to split misaligned SH/SW into two writes.

package store_pkg;
  typedef enum logic [3:0] {
    NOP, ADD, LB, LH, LW, LBU, LHU, LR_W,
    SB, SH, SW, SC_W, FENCE
  } iType_e;
endpackage

module store_unit
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  iType_e      instruction_operation_i,
  input  logic [31:0] address_i,
  input  logic [31:0] store_data_i,
  input  logic        lr_set_i,
  input  logic [31:0] lr_address_i,
  output logic        stall_o,
  output logic [31:0] sc_result_o,
  output logic        sc_result_valid_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_address_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_data_o,
  output logic        empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [29:0]   r_addr [DEPTH];
  logic [3:0]    r_we   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_res_valid;
  logic [29:0]   r_res_addr;
  logic          r_sc_result;
  logic          r_sc_valid;
  logic          r_mis;

  iType_e        w_op;
  logic [29:0]   w_word;
  logic          w_is_st;
  logic          w_is_sc;
  logic          w_mis;
  logic          w_trap;
  logic          w_two;
  logic [3:0]    w_we0;
  logic [31:0]   w_data0;
  logic [3:0]    w_lo_we;
  logic [31:0]   w_lo_data;
  logic [CW-1:0] w_need;
  logic [CW-1:0] w_free;
  logic          w_go;
  logic          w_sc_ok;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_npush;
  logic          w_unused;

  assign w_op     = instruction_operation_i;
  assign w_word   = address_i[31:2];
  assign w_is_sc  = (w_op == SC_W);
  assign w_unused = &{1'b0, lr_address_i[1:0]};

  always_comb begin
    w_is_st = 1'b0;
    w_mis   = 1'b0;
    w_we0   = 4'b0000;
    w_data0 = 32'h0;
    unique case (1'b1)
      (w_op == SB): begin
        w_is_st = 1'b1;
        w_we0   = 4'b0001 << address_i[1:0];
        w_data0 = {4{store_data_i[7:0]}};
      end
      (w_op == SH): begin
        w_is_st = 1'b1;
        w_we0   = address_i[1] ? 4'b1100 : 4'b0011;
        w_data0 = {2{store_data_i[15:0]}};
        w_mis   = address_i[0];
      end
      (w_op == SW) || (w_op == SC_W): begin
        w_is_st = 1'b1;
        w_we0   = 4'b1111;
        w_data0 = store_data_i;
        w_mis   = |address_i[1:0];
      end
      default: ;
    endcase
  end

`ifdef STORE_MISALIGNED_SPLIT_EN
  // Shift a 64-bit window: low half is this word, high half the next.
  logic        w_split;
  logic [3:0]  w_base;
  logic [31:0] w_raw;
  logic [7:0]  w_se;
  logic [63:0] w_sd;
  logic [3:0]  w_we1;
  logic [31:0] w_data1;

  always_comb begin
    w_base  = (w_op == SH) ? 4'b0011 : 4'b1111;
    w_raw   = (w_op == SH) ? {16'h0, store_data_i[15:0]}
                           : store_data_i;
    w_se    = {4'b0000, w_base} << address_i[1:0];
    w_sd    = {32'h0, w_raw} << {address_i[1:0], 3'b000};
    w_split = w_mis && !w_is_sc;
    w_trap  = w_mis && w_is_sc;
    w_two   = w_split && (w_se[7:4] != 4'b0000);
    w_lo_we   = w_split ? w_se[3:0]  : w_we0;
    w_lo_data = w_split ? w_sd[31:0] : w_data0;
    w_we1   = w_se[7:4];
    w_data1 = w_sd[63:32];
  end
`else
  assign w_trap    = w_mis;
  assign w_two     = 1'b0;
  assign w_lo_we   = w_we0;
  assign w_lo_data = w_data0;
`endif

  assign w_need  = w_trap ? CW'(0) : (w_two ? CW'(2) : CW'(1));
  assign w_free  = CW'(DEPTH) - r_count;
  assign stall_o = valid_i && w_is_st && (w_free < w_need);
  assign w_go    = valid_i && w_is_st && !stall_o && !w_trap;
  assign w_sc_ok = r_res_valid && (w_word == r_res_addr);
  assign w_push  = w_go && (!w_is_sc || w_sc_ok);
  assign w_npush = w_push ? (w_two ? 2'd2 : 2'd1) : 2'd0;
  assign w_pop   = (r_count != CW'(0)) && mem_gnt_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_res_valid <= 1'b0;
      r_res_addr  <= '0;
      r_sc_result <= 1'b0;
      r_sc_valid  <= 1'b0;
      r_mis       <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_npush);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= r_count + CW'(w_npush) - CW'(w_pop);
      r_sc_valid <= w_go && w_is_sc;
      if (w_go && w_is_sc)
        r_sc_result <= !w_sc_ok;
      r_mis      <= valid_i && w_is_st && w_trap;
      // LR wins over a same-cycle SC clearing the reservation.
      if (lr_set_i) begin
        r_res_valid <= 1'b1;
        r_res_addr  <= lr_address_i[31:2];
      end else if (w_go && w_is_sc) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= w_word;
      r_we[r_wr_ptr]   <= w_lo_we;
      r_data[r_wr_ptr] <= w_lo_data;
    end
`ifdef STORE_MISALIGNED_SPLIT_EN
    if (w_push && w_two) begin
      r_addr[r_wr_ptr + AW'(1)] <= w_word + 30'd1;
      r_we[r_wr_ptr + AW'(1)]   <= w_we1;
      r_data[r_wr_ptr + AW'(1)] <= w_data1;
    end
`endif
  end

  assign mem_req_o         = (r_count != CW'(0));
  assign empty_o           = (r_count == CW'(0));
  assign mem_address_o     = {r_addr[r_rd_ptr], 2'b00};
  assign mem_we_o          = r_we[r_rd_ptr];
  assign mem_data_o        = r_data[r_rd_ptr];
  assign sc_result_o       = {31'h0, r_sc_result};
  assign sc_result_valid_o = r_sc_valid;
  assign misaligned_o      = r_mis;

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the load/retire path.
- Takes store operations (SB, SH, SW, SC_W) from execute and forms word-aligned memory writes: byte-enables plus replicated write data.
- Buffers them in a small FIFO and drains them to the data-memory port over a req/gnt handshake.
- Also owns the LR/SC reservation check for SC_W and returns the SC result to write-back.

Parameters:
DEPTH, 2, store buffer entries (power of two, >=2)

Ports:
clk  input  1  core clock
reset  input  1  synchronous reset, active-high
valid_i  input  1  operation presented this cycle
instruction_operation_i  input  iType_e  operation (SB, SH, SW, SC_W acted on; all others ignored)
address_i  input  32  effective byte address
store_data_i  input  32  rs2 value
lr_set_i  input  1  LR_W retiring this cycle; sets reservation
lr_address_i  input  32  LR_W byte address
stall_o  output  1  execute must hold current operation
sc_result_o  output  32  SC_W result: 0 success, 1 failure
sc_result_valid_o  output  1  sc_result_o valid (one-cycle pulse)
misaligned_o  output  1  misaligned store trap (one-cycle pulse)
mem_req_o  output  1  write request
mem_gnt_i  input  1  memory accepted head entry
mem_address_o  output  32  word address ({addr[31:2],2'b00})
mem_we_o  output  4  byte enables
mem_data_o  output  32  write data
empty_o  output  1  buffer drained (FENCE support)

Behaviour:
- Reset (clk edge with reset=1):
  - wr_ptr, rd_ptr, count = 0.
  - reservation_valid = 0.
  - mem_req_o, sc_result_valid_o, misaligned_o, stall_o = 0.
  - sc_result_o = 0; empty_o = 1.
  - Reset mid-drain discards all entries, including an ungranted head.
- Entry formation (combinational from inputs):
  - SB: we = 4'b0001 << addr[1:0]; data = {4{store_data_i[7:0]}}.
  - SH: we = addr[1] ? 4'b1100 : 4'b0011; data = {2{store_data_i[15:0]}}.
  - SW/SC_W: we = 4'b1111; data = store_data_i.
- Misalignment rules:
  - SH with addr[0]=1 is misaligned.
  - SW/SC_W with addr[1:0]!=0 is misaligned.
  - Handling is defined under Optional Feature.
- Accept: push when valid_i, op is a store, no stall_o, and not misaligned.
- stall_o:
  - Asserted when valid_i, op is a store, and free entries < required entries.
  - A same-cycle pop does not relieve the stall; no full-FIFO bypass.
  - Execute holds the operation until stall_o drops; the operation is then accepted exactly once.
- Drain:
  - mem_req_o = (count != 0); the head entry drives mem_address_o, mem_we_o and mem_data_o.
  - Pop on mem_req_o && mem_gnt_i.
  - The head stays stable while mem_req_o=1 and mem_gnt_i=0.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
- Reservation:
  - lr_set_i sets reservation_valid=1 and reservation_addr = lr_address_i[31:2].
  - SC_W accepted (not stalled):
    - Success when reservation_valid and address_i[31:2] == reservation_addr: enqueue as SW, sc_result_o=0.
    - Failure otherwise: nothing enqueued, sc_result_o=1.
    - sc_result_valid_o pulses one cycle after acceptance.
    - reservation_valid clears in either case.
  - lr_set_i and an accepted SC_W in the same cycle: the SC is evaluated against the old reservation; lr_set_i then wins and reservation_valid ends at 1.
  - A stalled SC_W produces no result and does not touch the reservation.
- Latency:
  - Store into an empty buffer: mem_req_o high the cycle after acceptance.
  - Throughput is one store per cycle with mem_gnt_i held at 1.
- empty_o = (count == 0).

Optional Feature:
Macro: STORE_MISALIGNED_SPLIT_EN
- Undefined:
  - A misaligned store is not enqueued and misaligned_o pulses one cycle after it is presented; stall_o is not asserted for it.
  - Misaligned SC_W also traps and leaves the reservation unchanged.
- Defined:
  - Misaligned SH/SW is split into two entries pushed in the same cycle: low word first, then high word.
  - Each entry gets its own byte-enables and correctly shifted data.
  - The store needs 2 free entries; otherwise stall_o.
  - misaligned_o is tied 0 for SH/SW. Misaligned SC_W still traps.

Test Plan:
- SB addr=0x1003, data=0xAB, gnt=1 -> next cycle mem_address_o=0x1000, mem_we_o=4'b1000, mem_data_o=0xABABABAB, mem_req_o=1 one cycle.
- SH addr=0x2002 data=0x1234 then SW addr=0x2004 data=0xDEADBEEF, gnt=0 for 5 cycles -> count=2, head (0x2000, 4'b1100, 0x12341234) held stable. A third SB sees stall_o=1. gnt=1 drains in order and the SB is then accepted.
- lr_set_i addr=0x3000, then SC_W addr=0x3000 data=7 -> sc_result_o=0, write (0x3000, 4'b1111, 7). A second SC_W at 0x3000 -> sc_result_o=1, no write.
- lr_set_i addr=0x3000, SC_W addr=0x3004 -> sc_result_o=1, no mem_req_o, reservation cleared.
- SW addr=0x4001 -> macro off: misaligned_o pulse, no request. Macro on: entries (0x4000, 4'b1110, data<<8) then (0x4004, 4'b0001, data>>24).
- Reset asserted while 2 entries pending and gnt=0 -> next cycle mem_req_o=0, empty_o=1, stall_o=0, no further writes.
